ucsbece154b_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters: the Fetch stage (I-side, read-only) and the Memory stage (D-side, load/store).
- Sequences one memory transaction at a time and returns data to the winning side.
- Generates stall requests (stall_f_o, stall_m_o) that the hazard unit ORs into StallF/StallD/StallE/StallM.
- Sits between the pipelined datapath and the memory model; replaces the separate imem/dmem ports.

---
 rtl/ucsbece154b_mem_arbiter_pkg.sv | 26 ++
 rtl/ucsbece154b_mem_arbiter_starve.sv | 33 +++
 rtl/ucsbece154b_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding, owner encoding,
// and the starvation counter width.
package ucsbece154b_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    arb_IDLE   = 3'd0,
    arb_I_REQ  = 3'd1,
    arb_I_WAIT = 3'd2,
    arb_D_REQ  = 3'd3,
    arb_D_WAIT = 3'd4,
    arb_I_DROP = 3'd5
  } arbState_t;

  typedef enum logic {
    own_I = 1'b0,
    own_D = 1'b1
  } arbOwner_t;

  localparam int unsigned StarveCntW = 3;

  // A response is only legal while a granted transaction is outstanding.
  function automatic logic rvalidIllegal(input arbState_t s);
    return (s == arb_IDLE) || (s == arb_I_REQ) || (s == arb_D_REQ);
  endfunction

endpackage

// File: rtl/ucsbece154b_mem_arbiter_starve.sv
// Starvation guard: counts D-side grants while a fetch waits and forces an I-side win.
// Only present when UCSBECE154B_ARB_STARVE_GUARD_EN is defined.
`ifdef UCSBECE154B_ARB_STARVE_GUARD_EN
module ucsbece154b_mem_arbiter_starve
  import ucsbece154b_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ifetchPending,
  input  logic dGrant,
  input  logic iGrant,
  output logic iForce
);

  logic [StarveCntW-1:0] starveCnt;

  // Saturates rather than wrapping so a stuck fetch never loses its priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (!ifetchPending || iGrant) begin
      starveCnt <= '0;
    end else if (dGrant && (starveCnt != '1)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  assign iForce = (starveCnt >= StarveCntW'(STARVE_LIMIT));

endmodule
`endif

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbitrates Fetch (I-side) and Memory-stage (D-side) accesses onto one single-ported memory.
// Define UCSBECE154B_ARB_STARVE_GUARD_EN to enable the I-side starvation guard.
module ucsbece154b_mem_arbiter
  import ucsbece154b_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_req_i,
  input  logic [31:0] ifetch_addr_i,
  input  logic        ifetch_kill_i,
  output logic [31:0] ifetch_rdata_o,
  output logic        ifetch_done_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_f_o,
  output logic        stall_m_o
);

  arbState_t state;
  arbOwner_t winner;
  logic      iElig, dElig, iForce;
  logic      driveI, driveD;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : gBadStarveLimit
    $error("STARVE_LIMIT must fit the 3-bit starvation counter (1..7)");
  end

  // A side whose done pulse is high this cycle is still holding its old request.
  assign iElig = ifetch_req_i & ~ifetch_done_o & ~ifetch_kill_i;
  assign dElig = dmem_req_i & ~dmem_done_o;

`ifdef UCSBECE154B_ARB_STARVE_GUARD_EN
  ucsbece154b_mem_arbiter_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk          (clk),
    .reset        (reset),
    .ifetchPending(ifetch_req_i),
    .dGrant       (driveD & mem_gnt_i),
    .iGrant       (driveI & mem_gnt_i),
    .iForce       (iForce)
  );
`else
  assign iForce = 1'b0;
`endif

  // The request is presented in the same cycle the decision is made, so the
  // memory side is purely combinational off the current state.
  always_comb begin
    winner = own_D;
    driveI = 1'b0;
    driveD = 1'b0;
    if (!reset) begin
      unique case (state)
        arb_IDLE: begin
          if (dElig && !(iForce && iElig)) begin
            winner = own_D;
            driveD = 1'b1;
          end else if (iElig) begin
            winner = own_I;
            driveI = 1'b1;
          end
        end
        arb_I_REQ: driveI = ~ifetch_kill_i;
        arb_D_REQ: driveD = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_req_o   = driveI | driveD;
  assign mem_we_o    = driveD & dmem_we_i;
  assign mem_addr_o  = driveD ? dmem_addr_i : (driveI ? ifetch_addr_i : 32'h0);
  assign mem_wdata_o = driveD ? dmem_wdata_i : 32'h0;

  assign stall_f_o = ~reset & ifetch_req_i & ~ifetch_done_o & ~ifetch_kill_i;
  assign stall_m_o = ~reset & dmem_req_i & ~dmem_done_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= arb_IDLE;
      ifetch_done_o  <= 1'b0;
      dmem_done_o    <= 1'b0;
      ifetch_rdata_o <= '0;
      dmem_rdata_o   <= '0;
    end else begin
      ifetch_done_o <= 1'b0;
      dmem_done_o   <= 1'b0;
      unique case (state)
        arb_IDLE: begin
          if (driveD || driveI) begin
            if (winner == own_D) state <= mem_gnt_i ? arb_D_WAIT : arb_D_REQ;
            else                 state <= mem_gnt_i ? arb_I_WAIT : arb_I_REQ;
          end
        end
        arb_I_REQ: begin
          // A grant that races the kill still leaves a response to absorb.
          if (ifetch_kill_i)  state <= mem_gnt_i ? arb_I_DROP : arb_IDLE;
          else if (mem_gnt_i) state <= arb_I_WAIT;
        end
        arb_I_WAIT: begin
          if (mem_rvalid_i) begin
            if (!ifetch_kill_i) begin
              ifetch_done_o  <= 1'b1;
              ifetch_rdata_o <= mem_rdata_i;
            end
            state <= arb_IDLE;
          end else if (ifetch_kill_i) begin
            state <= arb_I_DROP;
          end
        end
        arb_D_REQ: begin
          if (mem_gnt_i) state <= arb_D_WAIT;
        end
        arb_D_WAIT: begin
          if (mem_rvalid_i) begin
            dmem_done_o <= 1'b1;
            if (!dmem_we_i) dmem_rdata_o <= mem_rdata_i;
            state <= arb_IDLE;
          end
        end
        arb_I_DROP: begin
          if (mem_rvalid_i) state <= arb_IDLE;
        end
        default: state <= arb_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(mem_rvalid_i && rvalidIllegal(state)))
    else $error("mem_rvalid_i asserted with no granted transaction outstanding");

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed scoreboard bench for ucsbece154b_mem_arbiter; the starvation scenario runs
// only when UCSBECE154B_ARB_STARVE_GUARD_EN is defined.
module tb_ucsbece154b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifetchReq, ifetchKill, dmemReq, dmemWe, memGnt, memRvalid;
  logic [31:0] ifetchAddr, dmemAddr, dmemWdata, memRdata;
  logic [31:0] ifetchRdata, dmemRdata, memAddr, memWdata;
  logic        ifetchDone, dmemDone, memReq, memWe, stallF, stallM;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] iExp[$];
  logic [31:0] dExp[$];

  ucsbece154b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifetch_req_i  (ifetchReq),
    .ifetch_addr_i (ifetchAddr),
    .ifetch_kill_i (ifetchKill),
    .ifetch_rdata_o(ifetchRdata),
    .ifetch_done_o (ifetchDone),
    .dmem_req_i    (dmemReq),
    .dmem_we_i     (dmemWe),
    .dmem_addr_i   (dmemAddr),
    .dmem_wdata_i  (dmemWdata),
    .dmem_rdata_o  (dmemRdata),
    .dmem_done_o   (dmemDone),
    .mem_req_o     (memReq),
    .mem_we_o      (memWe),
    .mem_addr_o    (memAddr),
    .mem_wdata_o   (memWdata),
    .mem_gnt_i     (memGnt),
    .mem_rvalid_i  (memRvalid),
    .mem_rdata_i   (memRdata),
    .stall_f_o     (stallF),
    .stall_m_o     (stallM)
  );

  always #5 clk = ~clk;

  // Hard ceiling so a wedged run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic checkIResp(input string tag);
    checkOutput({tag, "_done"}, {31'd0, ifetchDone}, 32'd1);
    if (iExp.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      checkOutput({tag, "_rdata"}, ifetchRdata, iExp.pop_front());
    end
  endtask

  task automatic checkDResp(input string tag);
    checkOutput({tag, "_done"}, {31'd0, dmemDone}, 32'd1);
    if (dExp.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      checkOutput({tag, "_rdata"}, dmemRdata, dExp.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr, input logic fKill,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWd);
    ifetchReq  = fReq;
    ifetchAddr = fAddr;
    ifetchKill = fKill;
    dmemReq    = dReq;
    dmemWe     = dWe;
    dmemAddr   = dAddr;
    dmemWdata  = dWd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    memGnt = 1'b0;
    memRvalid = 1'b0;
    memRdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    settle();
    checkOutput("rst_memreq", {31'd0, memReq}, 32'd0);
    checkOutput("rst_idone", {31'd0, ifetchDone}, 32'd0);
    checkOutput("rst_ddone", {31'd0, dmemDone}, 32'd0);
    checkOutput("rst_irdata", ifetchRdata, 32'h0);
    checkOutput("rst_drdata", dmemRdata, 32'h0);
    reset = 1'b0;
    tick();

    $display("[TB] lone fetch");
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memGnt = 1'b1;
    settle();
    checkOutput("f1_req", {31'd0, memReq}, 32'd1);
    checkOutput("f1_addr", memAddr, 32'h0000_0010);
    checkOutput("f1_stall0", {31'd0, stallF}, 32'd1);
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h0050_0093;
    iExp.push_back(32'h0050_0093);
    settle();
    checkOutput("f1_stall1", {31'd0, stallF}, 32'd1);
    tick();
    memRvalid = 1'b0;
    settle();
    checkIResp("f1");
    checkOutput("f1_stall2", {31'd0, stallF}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    checkOutput("f1_pulse", {31'd0, ifetchDone}, 32'd0);
    tick();

    $display("[TB] simultaneous I and D");
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    memGnt = 1'b1;
    settle();
    checkOutput("arb_dfirst", memAddr, 32'h0000_0100);
    checkOutput("arb_dwe", {31'd0, memWe}, 32'd0);
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'hDEAD_BEEF;
    dExp.push_back(32'hDEAD_BEEF);
    settle();
    checkOutput("arb_stallm", {31'd0, stallM}, 32'd1);
    checkOutput("arb_stallf", {31'd0, stallF}, 32'd1);
    tick();
    memRvalid = 1'b0;
    settle();
    checkDResp("arb_d");
    checkOutput("arb_ireq", {31'd0, memReq}, 32'd1);
    checkOutput("arb_inext", memAddr, 32'h0000_0014);
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h00A0_0113;
    iExp.push_back(32'h00A0_0113);
    tick();
    memRvalid = 1'b0;
    settle();
    checkIResp("arb_i");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] store with delayed grant");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678);
    memGnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("st_req", {31'd0, memReq}, 32'd1);
      checkOutput("st_we", {31'd0, memWe}, 32'd1);
      checkOutput("st_addr", memAddr, 32'h0000_0200);
      checkOutput("st_wdata", memWdata, 32'h1234_5678);
      tick();
    end
    memGnt = 1'b1;
    settle();
    checkOutput("st_addr_gnt", memAddr, 32'h0000_0200);
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'hAAAA_AAAA;
    tick();
    memRvalid = 1'b0;
    settle();
    checkOutput("st_done", {31'd0, dmemDone}, 32'd1);
    checkOutput("st_rdata_kept", dmemRdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    checkOutput("st_done_once", {31'd0, dmemDone}, 32'd0);
    tick();

    $display("[TB] kill in I_WAIT");
    applyStimulus(1'b1, 32'h0000_0018, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    applyStimulus(1'b1, 32'h0000_0018, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("kill_stallf", {31'd0, stallF}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memRvalid = 1'b1;
    memRdata = 32'hFFFF_FFFF;
    settle();
    checkOutput("kill_noissue", {31'd0, memReq}, 32'd0);
    tick();
    memRvalid = 1'b0;
    settle();
    checkOutput("kill_nodone", {31'd0, ifetchDone}, 32'd0);
    checkOutput("kill_rdata_kept", ifetchRdata, 32'h00A0_0113);
    checkOutput("kill_reissue", {31'd0, memReq}, 32'd1);
    checkOutput("kill_newaddr", memAddr, 32'h0000_0040);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h0000_0013;
    iExp.push_back(32'h0000_0013);
    tick();
    memRvalid = 1'b0;
    settle();
    checkIResp("kill_next");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] async reset during D_WAIT");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_memreq", {31'd0, memReq}, 32'd0);
    checkOutput("ar_stallm", {31'd0, stallM}, 32'd0);
    checkOutput("ar_drdata", dmemRdata, 32'h0);
    checkOutput("ar_irdata", ifetchRdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memRvalid = 1'b1;
    memRdata = 32'h5555_5555;
    tick();
    reset = 1'b0;
    memRvalid = 1'b0;
    settle();
    checkOutput("ar_late_nodone", {31'd0, dmemDone}, 32'd0);
    tick();
    settle();
    checkOutput("ar_late_nodone2", {31'd0, dmemDone}, 32'd0);
    checkOutput("ar_late_rdata", dmemRdata, 32'h0);
    tick();

`ifdef UCSBECE154B_ARB_STARVE_GUARD_EN
    $display("[TB] starvation guard");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'h0000_0400 + 32'(k * 4), 32'h0);
      memGnt = 1'b1;
      settle();
      checkOutput("sv_dwin", memAddr, 32'h0000_0400 + 32'(k * 4));
      tick();
      memGnt = 1'b0;
      memRvalid = 1'b1;
      memRdata = 32'hC000_0000 + 32'(k);
      dExp.push_back(32'hC000_0000 + 32'(k));
      tick();
      memRvalid = 1'b0;
      applyStimulus(1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      checkDResp("sv_d");
      tick();
    end
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    memGnt = 1'b1;
    settle();
    checkOutput("sv_iwin", memAddr, 32'h0000_0080);
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h0000_0013;
    iExp.push_back(32'h0000_0013);
    tick();
    memRvalid = 1'b0;
    settle();
    checkIResp("sv_i");
    checkOutput("sv_dafter", memAddr, 32'h0000_0500);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    memRvalid = 1'b1;
    memRdata = 32'h0BAD_F00D;
    dExp.push_back(32'h0BAD_F00D);
    tick();
    memRvalid = 1'b0;
    settle();
    checkDResp("sv_dlast");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
